// File: rtl/uart_sample_rx_if.sv
// rtl/uart_sample_rx_if.sv - sample handshake between the UART front end and the filter core
interface uart_sample_rx_if;
   logic [15:0] sample_data;
   logic        sample_valid;
   logic        sample_ready;

   modport master (output sample_data, output sample_valid, input sample_ready);
   modport slave  (input sample_data, input sample_valid, output sample_ready);
endinterface

// File: rtl/uart_sample_rx.sv
// rtl/uart_sample_rx.sv - 8N1 UART receiver pairing bytes into 16-bit samples (high byte first)
// Optional even parity bit between data bit 7 and stop: define UART_SAMPLE_PARITY_EN.
module uart_sample_rx #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rx_data,
   uart_sample_rx_if.master sample,
   output logic             frame_err,
   output logic             overrun
);

   localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] HALF     = 16'(CLKS_PER_BIT / 2);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_SAMPLE_PARITY_EN
      PARITY,
`endif
      STOP,
      WAIT_IDLE
   } state_t;

   state_t      state;
   logic        rx_meta;
   logic        rx_sync;
   logic [15:0] cnt;
   logic [2:0]  bit_idx;
   logic [7:0]  shift;
   logic [7:0]  high;
   logic        phase;
   logic        par_bad;

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta             <= 1'b1;
         rx_sync             <= 1'b1;
         state               <= IDLE;
         cnt                 <= '0;
         bit_idx             <= '0;
         shift               <= '0;
         high                <= '0;
         phase               <= 1'b0;
         par_bad             <= 1'b0;
         sample.sample_data  <= '0;
         sample.sample_valid <= 1'b0;
         frame_err           <= 1'b0;
         overrun             <= 1'b0;
      end else begin
         rx_meta   <= rx_data;
         rx_sync   <= rx_meta;
         frame_err <= 1'b0;
         overrun   <= 1'b0;

         // A completing sample below may override this consume
         if (sample.sample_valid && sample.sample_ready)
            sample.sample_valid <= 1'b0;

         case (state)
            IDLE: begin
               cnt     <= '0;
               bit_idx <= '0;
               par_bad <= 1'b0;
               if (!rx_sync)
                  state <= START;
            end
            START: begin
               if (cnt == HALF) begin
                  cnt   <= '0;
                  state <= rx_sync ? IDLE : DATA;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            DATA: begin
               if (cnt == BIT_LAST) begin
                  cnt     <= '0;
                  shift   <= {rx_sync, shift[7:1]};
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
`ifdef UART_SAMPLE_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
`ifdef UART_SAMPLE_PARITY_EN
            PARITY: begin
               if (cnt == BIT_LAST) begin
                  cnt   <= '0;
                  state <= STOP;
                  if (rx_sync != ^shift) begin
                     par_bad   <= 1'b1;
                     frame_err <= 1'b1;
                     phase     <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
`endif
            STOP: begin
               if (cnt == BIT_LAST) begin
                  cnt <= '0;
                  if (rx_sync) begin
                     state <= IDLE;
                     if (!par_bad) begin
                        if (!phase) begin
                           high  <= shift;
                           phase <= 1'b1;
                        end else begin
                           phase <= 1'b0;
                           if (!sample.sample_valid || sample.sample_ready) begin
                              sample.sample_data  <= {high, shift};
                              sample.sample_valid <= 1'b1;
                           end else begin
                              overrun <= 1'b1;
                           end
                        end
                     end
                  end else begin
                     // Parity failure already flagged this byte; no second pulse
                     state <= WAIT_IDLE;
                     phase <= 1'b0;
                     if (!par_bad)
                        frame_err <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            WAIT_IDLE: begin
               if (rx_sync)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_sample_rx.sv
// tb/tb_uart_sample_rx.sv - directed scoreboard bench for uart_sample_rx
module tb_uart_sample_rx;
   localparam int CPB = 16;

   logic clk = 1'b0;
   logic reset;
   logic rx_data;
   logic frame_err;
   logic overrun;

   uart_sample_rx_if sif();

   uart_sample_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk       (clk),
      .reset     (reset),
      .rx_data   (rx_data),
      .sample    (sif),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int fe_cnt = 0;
   int ov_cnt = 0;
   int both_cnt = 0;
   logic [15:0] sb[$];

`ifdef UART_SAMPLE_PARITY_EN
   bit bad_par = 1'b0;
`endif

   always @(negedge clk) begin
      if (frame_err === 1'b1) fe_cnt++;
      if (overrun === 1'b1) ov_cnt++;
      if (frame_err === 1'b1 && overrun === 1'b1) both_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop, input int gap);
      rx_data = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_data = b[i];
         repeat (CPB) @(negedge clk);
      end
`ifdef UART_SAMPLE_PARITY_EN
      rx_data = bad_par ? ~(^b) : ^b;
      repeat (CPB) @(negedge clk);
`endif
      rx_data = stop;
      repeat (CPB) @(negedge clk);
      rx_data = 1'b1;
      repeat (gap) @(negedge clk);
   endtask

   task automatic send_pair(input logic [15:0] s, input bit push);
      send_byte(s[15:8], 1'b1, 0);
      if (push) sb.push_back(s);
      send_byte(s[7:0], 1'b1, 0);
   endtask

   task automatic expect_sample(input string tag);
      int n = 0;
      logic [15:0] e;
      while (sif.sample_valid !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_valid"}, 32'(sif.sample_valid), 32'd1);
      if (sif.sample_valid === 1'b1) begin
         check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
         e = (sb.size() > 0) ? sb.pop_front() : 16'h0000;
         check({tag, "_data"}, 32'(sif.sample_data), 32'(e));
         repeat (5) @(negedge clk);
         check({tag, "_held_valid"}, 32'(sif.sample_valid), 32'd1);
         check({tag, "_held_data"}, 32'(sif.sample_data), 32'(e));
         sif.sample_ready = 1'b1;
         @(negedge clk);
         sif.sample_ready = 1'b0;
         check({tag, "_consumed"}, 32'(sif.sample_valid), 32'd0);
         check({tag, "_data_kept"}, 32'(sif.sample_data), 32'(e));
      end
   endtask

   initial begin
      int fe0;
      int ov0;
      reset = 1'b1;
      rx_data = 1'b1;
      sif.sample_ready = 1'b0;
      repeat (4) @(negedge clk);
      check("rst_valid", 32'(sif.sample_valid), 32'd0);
      check("rst_data", 32'(sif.sample_data), 32'd0);
      check("rst_frame_err", 32'(frame_err), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      reset = 1'b0;
      repeat (10) @(negedge clk);

      // Basic pair
      send_pair(16'h1234, 1'b1);
      expect_sample("pair_1234");

      // Bad stop bit on the second byte discards the partial pair
      fe0 = fe_cnt;
      send_byte(8'hAB, 1'b1, 0);
      send_byte(8'hCD, 1'b0, 4);
      repeat (4) @(negedge clk);
      check("ferr_pulse", 32'(fe_cnt - fe0), 32'd1);
      check("ferr_no_sample", 32'(sif.sample_valid), 32'd0);
      send_pair(16'h5678, 1'b1);
      expect_sample("after_ferr");

      // Overrun: second sample dropped while the first is held
      ov0 = ov_cnt;
      fe0 = fe_cnt;
      send_pair(16'h0001, 1'b1);
      send_pair(16'h0002, 1'b0);
      repeat (4) @(negedge clk);
      check("overrun_pulse", 32'(ov_cnt - ov0), 32'd1);
      check("overrun_no_ferr", 32'(fe_cnt - fe0), 32'd0);
      expect_sample("overrun_held");

      // Short glitch on the idle line
      ov0 = ov_cnt;
      fe0 = fe_cnt;
      rx_data = 1'b0;
      repeat (4) @(negedge clk);
      rx_data = 1'b1;
      repeat (40) @(negedge clk);
      check("glitch_valid", 32'(sif.sample_valid), 32'd0);
      check("glitch_ferr", 32'(fe_cnt - fe0), 32'd0);
      check("glitch_ovr", 32'(ov_cnt - ov0), 32'd0);
      send_pair(16'hFFFF, 1'b1);
      expect_sample("pair_ffff");

      // Reset during bit 3 of the second byte
      ov0 = ov_cnt;
      send_byte(8'h0A, 1'b1, 0);
      rx_data = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         rx_data = i[0];
         repeat (CPB) @(negedge clk);
      end
      rx_data = 1'b1;
      repeat (CPB / 2) @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (20) @(negedge clk);
      check("midrst_valid", 32'(sif.sample_valid), 32'd0);
      check("midrst_ovr", 32'(ov_cnt - ov0), 32'd0);
      send_pair(16'h0A0B, 1'b1);
      expect_sample("after_rst");

`ifdef UART_SAMPLE_PARITY_EN
      fe0 = fe_cnt;
      send_byte(8'h12, 1'b1, 0);
      bad_par = 1'b1;
      send_byte(8'h34, 1'b1, 4);
      bad_par = 1'b0;
      repeat (4) @(negedge clk);
      check("par_pulse", 32'(fe_cnt - fe0), 32'd1);
      check("par_no_sample", 32'(sif.sample_valid), 32'd0);
      send_pair(16'h1234, 1'b1);
      expect_sample("par_good");
`endif

      repeat (10) @(negedge clk);
      check("sb_drained", 32'(sb.size()), 32'd0);
      check("no_overlap", 32'(both_cnt), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout observed running expected finished");
      $fatal(1, "timeout");
   end
endmodule
